// File: rtl/xillybus_stream_pkg.sv
// Shared types for the Xillybus write-stream packer: FSM states, lane-count
// width helper and the FIFO entry layout for the default 8-bit x2 build.
package xillybus_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    FL_PEND = 2'd2,
    FL_PART = 2'd3
  } wsp_state_t;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 2;

  // Lane-count width for the default build; use lane_width() for other ratios.
  localparam int LANE_W = $clog2(DEF_RATIO + 1);

  // Width of a field that must hold 0..ratio inclusive.
  function automatic int lane_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // FIFO entry for the default build. The packer declares a locally sized
  // copy of this layout so that other IN_W/RATIO values work.
  typedef struct packed {
    logic [DEF_IN_W*DEF_RATIO-1:0] data;
    logic [LANE_W-1:0]             lanes;
    logic                          last;
  } wsp_entry_t;

endpackage

// File: rtl/xillybus_sync_fifo.sv
// First-word fall-through synchronous FIFO. The storage array is read
// through a registered head stage so that it maps onto block RAM. The
// reported count includes the head register.
module xillybus_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH)+1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      mem_count_reg;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             load;

  // Refill the head register whenever it is empty or being consumed.
  assign load = (mem_count_reg != '0) && (!head_valid_reg || pop);

  // Storage array write port (no reset so it can infer block RAM).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers, occupancy and the registered head stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        head_data_reg <= mem[rd_ptr_reg];
      end
      mem_count_reg <= mem_count_reg + (AW+1)'(push) - (AW+1)'(load);
      if (load)     head_valid_reg <= 1'b1;
      else if (pop) head_valid_reg <= 1'b0;
    end
  end

  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;
  assign count      = (AW+2)'(mem_count_reg) + (AW+2)'(head_valid_reg);

endmodule

// File: rtl/xillybus_wstream_packer.sv
// Xillybus write-stream endpoint: packs RATIO host words into one wide word,
// holds the newest complete word back so close can tag it as last, flushes a
// padded partial word on close and buffers everything in a FWFT FIFO.
module xillybus_wstream_packer
  import xillybus_stream_pkg::*;
#(
  parameter int              IN_W      = 8,
  parameter int              RATIO     = 2,
  parameter int              DEPTH     = 16,
  parameter int              MSB_FIRST = 1,
  parameter logic [IN_W-1:0] PAD       = '0
) (
  input  logic                         bus_clk,
  input  logic                         trn_reset_n,
  input  logic                         user_w_wren,
  input  logic [IN_W-1:0]              user_w_data,
  output logic                         user_w_full,
  input  logic                         user_w_open,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_W*RATIO-1:0]        out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_lanes,
  output logic                         out_last,
  output logic                         overflow
);

  localparam int DW = IN_W * RATIO;
  localparam int LW = lane_width(RATIO);
  localparam int CW = $clog2(DEPTH) + 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LW-1:0] lanes;
    logic          last;
  } entry_t;

  wsp_state_t    state_reg, state_next;
  logic [LW-1:0] lane_cnt_reg, lane_cnt_next;
  logic [DW-1:0] word_reg, word_next, partial_word;
  logic [DW-1:0] pend_reg;
  logic          pend_valid_reg;
  logic          overflow_reg, open_prev_reg;
  logic          accept, word_done, flushing, push, pop;
  entry_t        push_entry, head_entry;
  logic [CW-1:0] fifo_count;

  assign flushing    = (state_reg == FL_PEND) || (state_reg == FL_PART);
  assign user_w_full = (fifo_count >= CW'(DEPTH - 2)) || flushing;
  assign accept      = user_w_wren && !user_w_full &&
                       ((state_reg == OPEN) || (state_reg == IDLE && user_w_open));
  assign word_done   = accept && (lane_cnt_reg == LW'(RATIO - 1));

  // Per-lane steering: logical lane gi lands in physical slot PHYS.
  // Lanes at or beyond lane_cnt are replaced by PAD in the flush word.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam int PHYS = (MSB_FIRST != 0) ? (RATIO - 1 - gi) : gi;
      assign word_next[PHYS*IN_W +: IN_W] =
        (accept && lane_cnt_reg == LW'(gi)) ? user_w_data : word_reg[PHYS*IN_W +: IN_W];
      assign partial_word[PHYS*IN_W +: IN_W] =
        (LW'(gi) < lane_cnt_reg) ? word_reg[PHYS*IN_W +: IN_W] : PAD;
    end
  endgenerate

  // Next state, FIFO push selection and lane counter update.
  always_comb begin
    state_next    = state_reg;
    lane_cnt_next = lane_cnt_reg;
    push          = 1'b0;
    push_entry    = '0;
    unique case (state_reg)
      IDLE:    if (user_w_open)  state_next = OPEN;
      OPEN:    if (!user_w_open) state_next = FL_PEND;
      FL_PEND: begin
        state_next = (lane_cnt_reg != '0) ? FL_PART : IDLE;
        if (pend_valid_reg) begin
          push       = 1'b1;
          push_entry = '{data: pend_reg, lanes: LW'(RATIO), last: (lane_cnt_reg == '0)};
        end
      end
      FL_PART: begin
        state_next    = IDLE;
        push          = 1'b1;
        push_entry    = '{data: partial_word, lanes: lane_cnt_reg, last: 1'b1};
        lane_cnt_next = '0;
      end
      default: state_next = IDLE;
    endcase
    // Writes are only accepted in IDLE/OPEN, so this never collides with a flush push.
    if (accept) begin
      lane_cnt_next = word_done ? '0 : lane_cnt_reg + LW'(1);
      if (word_done && pend_valid_reg) begin
        push       = 1'b1;
        push_entry = '{data: pend_reg, lanes: LW'(RATIO), last: 1'b0};
      end
    end
  end

  // State, lane assembly and the one-word hold-back register.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_reg      <= IDLE;
      lane_cnt_reg   <= '0;
      word_reg       <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lane_cnt_reg <= lane_cnt_next;
      word_reg     <= word_next;
      if (word_done) begin
        pend_reg       <= word_next;
        pend_valid_reg <= 1'b1;
      end else if (state_reg == FL_PEND) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  // Sticky overflow: set by any dropped write, cleared when a new session opens.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      overflow_reg  <= 1'b0;
      open_prev_reg <= 1'b0;
    end else begin
      open_prev_reg <= user_w_open;
      if (user_w_wren && !accept)             overflow_reg <= 1'b1;
      else if (user_w_open && !open_prev_reg) overflow_reg <= 1'b0;
    end
  end

  assign pop = out_valid && out_ready;

  xillybus_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (bus_clk),
    .rst_n      (trn_reset_n),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  assign out_data  = head_entry.data;
  assign out_lanes = head_entry.lanes;
  assign out_last  = head_entry.last;
  assign overflow  = overflow_reg;

endmodule
